// File: rtl/display_temperatura.sv
// Four-digit multiplexed 7-segment driver: units, tens, blank and alert level.
// Optional alarm blinking compiled in with DISPLAY_TEMPERATURA_BLINK_EN.
module display_temperatura #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Temperatura,
  input  logic [1:0] Alerta,
  input  logic       Alarma,
  output logic [7:0] Catodo,
  output logic [3:0] Seleccion,
  output logic       Frame_done
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  localparam logic [1:0] IDX_UNITS = 2'd0;
  localparam logic [1:0] IDX_TENS  = 2'd1;
  localparam logic [1:0] IDX_BLANK = 2'd2;
  localparam logic [1:0] IDX_ALERT = 2'd3;

  localparam logic [3:0] DIG_BLANK = 4'hF;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [4:0]    temp_q, temp_d;
  logic [1:0]    alerta_q, alerta_d;
  logic [7:0]    cat_q, cat_d;
  logic [3:0]    sel_q, sel_d;
  logic          tick, wrap;
  logic [1:0]    tens;
  logic [3:0]    units;
  logic [3:0]    digit;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'b0000_0011;
      4'd1:    seg7 = 8'b1001_1111;
      4'd2:    seg7 = 8'b0010_0101;
      4'd3:    seg7 = 8'b0000_1101;
      4'd4:    seg7 = 8'b1001_1001;
      4'd5:    seg7 = 8'b0100_1001;
      4'd6:    seg7 = 8'b0100_0001;
      4'd7:    seg7 = 8'b0001_1111;
      4'd8:    seg7 = 8'b0000_0001;
      4'd9:    seg7 = 8'b0000_1001;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign tick       = (presc_q == PRESC_MAX);
  assign wrap       = tick && (idx_q == IDX_ALERT);
  assign Frame_done = wrap;

  // The digit shown right after a wrap must already use the freshly latched values.
  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    temp_d   = wrap ? Temperatura : temp_q;
    alerta_d = wrap ? Alerta : alerta_q;
  end

  always_comb begin
    tens  = 2'd0;
    units = temp_d[3:0];
    if (temp_d >= 5'd30) begin
      tens  = 2'd3;
      units = 4'(temp_d - 5'd30);
    end else if (temp_d >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(temp_d - 5'd20);
    end else if (temp_d >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(temp_d - 5'd10);
    end
  end

  always_comb begin
    digit = DIG_BLANK;
    case (idx_d)
      IDX_UNITS: digit = units;
      IDX_TENS:  digit = (tens == 2'd0) ? DIG_BLANK : {2'b00, tens};
      IDX_BLANK: digit = DIG_BLANK;
      IDX_ALERT: digit = {2'b00, alerta_d};
      default:   digit = DIG_BLANK;
    endcase
    cat_d = tick ? seg7(digit) : cat_q;
    sel_d = tick ? ~(4'b0001 << idx_d) : sel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      idx_q    <= IDX_ALERT;
      temp_q   <= '0;
      alerta_q <= '0;
      cat_q    <= 8'hFF;
      sel_q    <= 4'b1111;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      temp_q   <= temp_d;
      alerta_q <= alerta_d;
      cat_q    <= cat_d;
      sel_q    <= sel_d;
    end
  end

  assign Catodo = cat_q;

`ifdef DISPLAY_TEMPERATURA_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blank_q, blank_d;

  // blink_cnt_q counts frames already shown in the current phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blank_d     = blank_q;
    if (!Alarma) begin
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (wrap) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = BW'(1);
        blank_d     = ~blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign Seleccion = sel_q | {4{blank_q}};
`else
  logic unused_alarma;
  assign unused_alarma = Alarma;
  assign Seleccion     = sel_q;
`endif

endmodule

// File: tb/tb_display_temperatura.sv
// Directed bench for display_temperatura with REFRESH_DIV=4, BLINK_FRAMES=2.
// Blink checks follow DISPLAY_TEMPERATURA_BLINK_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_display_temperatura;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Temperatura;
  logic [1:0] Alerta;
  logic       Alarma;
  logic [7:0] Catodo;
  logic [3:0] Seleccion;
  logic       Frame_done;

  int tests = 0;
  int fails = 0;

  display_temperatura #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .Temperatura(Temperatura),
    .Alerta     (Alerta),
    .Alarma     (Alarma),
    .Catodo     (Catodo),
    .Seleccion  (Seleccion),
    .Frame_done (Frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] t;
    logic [1:0] a;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
    logic [7:0] c3;
  } vec_t;

  vec_t vecs[9];
  logic [3:0] exp_sel[4];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame(input string name);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (Frame_done !== 1'b1 && cnt < 64) begin
      @(negedge clk);
      cnt++;
    end
    if (Frame_done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s: Frame_done got 0 expected 1 within 64 cycles", name);
    end
  endtask

  // Called on the negedge where Frame_done is high; samples first cycle of each digit.
  task automatic check_frame(input string name, input vec_t v);
    logic [7:0] c[4];
    c[0] = v.c0; c[1] = v.c1; c[2] = v.c2; c[3] = v.c3;
    for (int k = 0; k < 4; k++) begin
      step(k == 0 ? 1 : 4);
      chk($sformatf("%s cat idx%0d", name, k), Catodo, c[k]);
      chk($sformatf("%s sel idx%0d", name, k), {4'h0, Seleccion}, {4'h0, exp_sel[k]});
    end
  endtask

  // Called on a negedge with rst high for at least one edge; releases it.
  task automatic reset_seq(input string name, input logic [7:0] exp_c0);
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("%s sel c%0d", name, c), {4'h0, Seleccion}, 8'h0F);
      chk($sformatf("%s cat c%0d", name, c), Catodo, 8'hFF);
      chk($sformatf("%s fd c%0d", name, c), {7'd0, Frame_done}, (c == 4) ? 8'd1 : 8'd0);
      step(1);
    end
    chk($sformatf("%s sel c5", name), {4'h0, Seleccion}, 8'h0E);
    chk($sformatf("%s cat c5", name), Catodo, exp_c0);
    chk($sformatf("%s fd c5", name), {7'd0, Frame_done}, 8'd0);
  endtask

  initial begin
    exp_sel[0] = 4'b1110; exp_sel[1] = 4'b1101;
    exp_sel[2] = 4'b1011; exp_sel[3] = 4'b0111;
    vecs[0] = '{5'd25, 2'd2, 8'b0100_1001, 8'b0010_0101, 8'hFF, 8'b0010_0101};
    vecs[1] = '{5'd7,  2'd0, 8'b0001_1111, 8'hFF,        8'hFF, 8'b0000_0011};
    vecs[2] = '{5'd0,  2'd3, 8'b0000_0011, 8'hFF,        8'hFF, 8'b0000_1101};
    vecs[3] = '{5'd10, 2'd1, 8'b0000_0011, 8'b1001_1111, 8'hFF, 8'b1001_1111};
    vecs[4] = '{5'd31, 2'd0, 8'b1001_1111, 8'b0000_1101, 8'hFF, 8'b0000_0011};
    vecs[5] = '{5'd19, 2'd2, 8'b0000_1001, 8'b1001_1111, 8'hFF, 8'b0010_0101};
    vecs[6] = '{5'd28, 2'd3, 8'b0000_0001, 8'b0010_0101, 8'hFF, 8'b0000_1101};
    vecs[7] = '{5'd16, 2'd1, 8'b0100_0001, 8'b1001_1111, 8'hFF, 8'b1001_1111};
    vecs[8] = '{5'd24, 2'd0, 8'b1001_1001, 8'b0010_0101, 8'hFF, 8'b0000_0011};

    rst = 1'b1; Temperatura = 5'd0; Alerta = 2'd0; Alarma = 1'b0;
    step(3);
    reset_seq("rst0", 8'b0000_0011);

    for (int i = 0; i < 9; i++) begin
      Temperatura = vecs[i].t;
      Alerta      = vecs[i].a;
      wait_frame($sformatf("vec%0d", i));
      check_frame($sformatf("vec%0d", i), vecs[i]);
    end

    // Frame_done must be exactly one cycle wide.
    wait_frame("fd_width");
    step(1);
    chk("fd width", {7'd0, Frame_done}, 8'd0);

    // Input change mid-frame is held off until the next frame.
    Temperatura = 5'd25; Alerta = 2'd2;
    wait_frame("mid");
    step(1);
    chk("mid idx0", Catodo, 8'b0100_1001);
    step(4);
    chk("mid idx1", Catodo, 8'b0010_0101);
    Temperatura = 5'd13;
    step(4);
    chk("mid idx2", Catodo, 8'hFF);
    step(4);
    chk("mid idx3", Catodo, 8'b0010_0101);
    wait_frame("mid next");
    step(1);
    chk("mid next idx0", Catodo, 8'b0000_1101);
    step(4);
    chk("mid next idx1", Catodo, 8'b1001_1111);

    Alarma = 1'b1;
`ifdef DISPLAY_TEMPERATURA_BLINK_EN
    for (int f = 1; f <= 6; f++) begin
      wait_frame($sformatf("blink f%0d", f));
      step(1);
      chk($sformatf("blink f%0d idx0", f), {4'h0, Seleccion}, (f == 3 || f == 4) ? 8'h0F : 8'h0E);
      step(8);
      chk($sformatf("blink f%0d idx2", f), {4'h0, Seleccion}, (f == 3 || f == 4) ? 8'h0F : 8'h0B);
    end
    wait_frame("blink f7");
    step(5);
    chk("blink f7 blank", {4'h0, Seleccion}, 8'h0F);
    Alarma = 1'b0;
    step(1);
    chk("blink off visible", {4'h0, Seleccion}, 8'h0D);
`else
    for (int f = 1; f <= 4; f++) begin
      wait_frame($sformatf("noblink f%0d", f));
      step(1);
      chk($sformatf("noblink f%0d idx0", f), {4'h0, Seleccion}, 8'h0E);
    end
    Alarma = 1'b0;
`endif

    // Reset during index 2 restarts the sequence.
    Temperatura = 5'd25;
    wait_frame("rst mid");
    step(9);
    chk("rst mid pre sel", {4'h0, Seleccion}, 8'h0B);
    rst = 1'b1;
    step(1);
    chk("rst mid sel", {4'h0, Seleccion}, 8'h0F);
    chk("rst mid cat", Catodo, 8'hFF);
    chk("rst mid fd", {7'd0, Frame_done}, 8'd0);
    reset_seq("rst1", 8'b0100_1001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
